shader_issue_ctrl: RTL and testbench

- Instruction fetch/decode/issue sequencer that sits directly upstream of the shader core.
- Fetches 32-bit instructions from instruction memory and decodes opcode/rd/rs1/rs2.
- Drives the shader core's execute enable, holding all fields stable through the core's one-cycle-delayed writeback.
- Arbitrates the core's data-memory handshake for load/store opcodes and runs until a HALT instruction.

---
 rtl/shader_issue_ctrl.sv | 135 +++++++++++++
 tb/tb_shader_issue_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shader_issue_ctrl.sv
`default_nettype none
// shader_issue_ctrl: instruction fetch/decode/issue sequencer feeding the shader core.
// Define SHADER_ISSUE_PERF_EN to add saturating instr/stall/busy-cycle counters.
module shader_issue_ctrl #(
  parameter int         PC_WIDTH    = 10,
  parameter int         INSTR_WIDTH = 32,
  parameter logic [4:0] OP_LOAD     = 5'h10,
  parameter logic [4:0] OP_STORE    = 5'h11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [PC_WIDTH-1:0]    i_start_pc,
  input  logic                   i_abort,
  output logic                   o_imem_req,
  output logic [PC_WIDTH-1:0]    o_imem_addr,
  input  logic                   i_imem_valid,
  input  logic [INSTR_WIDTH-1:0] i_imem_data,
  output logic                   o_exec_en,
  output logic [4:0]             o_opcode,
  output logic [3:0]             o_rd_addr,
  output logic [3:0]             o_rs1_addr,
  output logic [3:0]             o_rs2_addr,
  output logic                   o_mem_req,
  input  logic                   i_mem_ready,
  output logic                   o_busy,
  output logic                   o_done,
`ifdef SHADER_ISSUE_PERF_EN
  output logic [31:0]            o_perf_instr,
  output logic [31:0]            o_perf_stall,
  output logic [31:0]            o_perf_cycles,
`endif
  output logic [PC_WIDTH-1:0]    o_pc
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_HALT = 5'h1F;

  logic [2:0]          r_state;
  logic [2:0]          w_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [16:0]         r_ir;
  logic [4:0]          w_op;
  logic                w_unused;

  // Only the decoded fields [31:15] are kept; the low bits carry nothing for issue.
  assign w_op     = r_ir[16:12];
  assign w_unused = &{1'b0, i_imem_data[14:0]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_FETCH;
      S_FETCH:  if (i_imem_valid) w_next = S_DECODE;
      S_DECODE: begin
        if (w_op == OP_HALT)                         w_next = S_DONE;
        else if (w_op == OP_NOP)                     w_next = S_FETCH;
        else if (w_op == OP_LOAD || w_op == OP_STORE) w_next = S_MEM;
        else                                         w_next = S_EXEC;
      end
      S_MEM:    if (i_mem_ready) w_next = S_EXEC;
      S_EXEC:   w_next = S_WB;
      S_WB:     w_next = S_FETCH;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (i_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (!i_abort) begin
        if (r_state == S_IDLE && i_start) r_pc <= i_start_pc;
        if (r_state == S_FETCH && i_imem_valid) r_ir <= i_imem_data[31:15];
        // PC advances only once the instruction has fully retired (after WB or a NOP decode).
        if ((r_state == S_DECODE && w_op == OP_NOP) || r_state == S_WB)
          r_pc <= r_pc + PC_WIDTH'(1);
      end
    end
  end

  assign o_imem_req  = (r_state == S_FETCH);
  assign o_imem_addr = r_pc;
  assign o_exec_en   = (r_state == S_EXEC);
  assign o_mem_req   = (r_state == S_MEM);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_pc        = r_pc;
  assign o_opcode    = r_ir[16:12];
  assign o_rd_addr   = r_ir[11:8];
  assign o_rs1_addr  = r_ir[7:4];
  assign o_rs2_addr  = r_ir[3:0];

`ifdef SHADER_ISSUE_PERF_EN
  logic [31:0] r_perf_instr;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_cycles;
  logic        w_perf_clr;
  logic        w_stall;

  assign w_perf_clr = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_stall    = (r_state == S_FETCH && !i_imem_valid) || (r_state == S_MEM && !i_mem_ready);

  always_ff @(posedge clk) begin
    if (rst || w_perf_clr) begin
      r_perf_instr  <= '0;
      r_perf_stall  <= '0;
      r_perf_cycles <= '0;
    end else begin
      if (r_state == S_EXEC && r_perf_instr != '1) r_perf_instr <= r_perf_instr + 32'd1;
      if (w_stall && r_perf_stall != '1)           r_perf_stall <= r_perf_stall + 32'd1;
      if (o_busy && r_perf_cycles != '1)           r_perf_cycles <= r_perf_cycles + 32'd1;
    end
  end

  assign o_perf_instr  = r_perf_instr;
  assign o_perf_stall  = r_perf_stall;
  assign o_perf_cycles = r_perf_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shader_issue_ctrl.sv
`default_nettype none
// tb_shader_issue_ctrl: directed and random programs checked against a program-level model.
module tb_shader_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst, i_start, i_abort, i_imem_valid, i_mem_ready;
  logic [9:0]  i_start_pc;
  logic [31:0] i_imem_data;
  logic        o_imem_req, o_exec_en, o_mem_req, o_busy, o_done;
  logic [9:0]  o_imem_addr, o_pc;
  logic [4:0]  o_opcode;
  logic [3:0]  o_rd_addr, o_rs1_addr, o_rs2_addr;
`ifdef SHADER_ISSUE_PERF_EN
  logic [31:0] o_perf_instr, o_perf_stall, o_perf_cycles;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] imem [0:1023];
  logic [31:0] ir_model;

  shader_issue_ctrl dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_start_pc(i_start_pc), .i_abort(i_abort),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_valid(i_imem_valid),
    .i_imem_data(i_imem_data), .o_exec_en(o_exec_en), .o_opcode(o_opcode),
    .o_rd_addr(o_rd_addr), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .o_mem_req(o_mem_req), .i_mem_ready(i_mem_ready), .o_busy(o_busy), .o_done(o_done),
`ifdef SHADER_ISSUE_PERF_EN
    .o_perf_instr(o_perf_instr), .o_perf_stall(o_perf_stall), .o_perf_cycles(o_perf_cycles),
`endif
    .o_pc(o_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, rs2, 15'($urandom)};
  endfunction

  function automatic logic [16:0] fld(input logic [31:0] w);
    return w[31:15];
  endfunction

  function automatic logic [16:0] dut_fields();
    return {o_opcode, o_rd_addr, o_rs1_addr, o_rs2_addr};
  endfunction

  function automatic bit is_mem(input logic [31:0] w);
    return (w[31:27] == 5'h10) || (w[31:27] == 5'h11);
  endfunction

  function automatic int pick(input int lat);
    return (lat < 0) ? int'($urandom_range(0, 3)) : lat;
  endfunction

  // Runs one program from spc; ilat/mlat < 0 select random latencies 0..3.
  task automatic run_prog(input logic [9:0] spc, input int ilat, input int mlat, input bit abort_mem);
    logic [31:0] expq[$];
    logic [9:0]  p, fetch_pc, instr_pc, halt_pc;
    int          guard, cyc, ei, iw, mw, cur_il, cur_ml, fv_cyc, mr_cyc, done_cyc;
    int          mem_cyc, exp_mem_cyc, stalls;
    bit          in_wb, done_seen, aborted;
    p = spc;
    guard = 0;
    while (imem[p][31:27] != 5'h1F && guard < 1024) begin
      if (imem[p][31:27] != 5'h00) expq.push_back(imem[p]);
      p++;
      guard++;
    end
    halt_pc = p;

    @(negedge clk);
    i_start = 1'b1;
    i_start_pc = spc;
    @(negedge clk);
    i_start = 1'b0;
`ifdef SHADER_ISSUE_PERF_EN
    chk("perf_clear", o_perf_instr | o_perf_stall | o_perf_cycles, 0);
`endif
    cyc = 1; ei = 0; iw = 0; mw = 0; cur_il = pick(ilat); cur_ml = pick(mlat);
    fv_cyc = -1000; mr_cyc = -1000; done_cyc = 0; mem_cyc = 0; exp_mem_cyc = 0; stalls = 0;
    in_wb = 0; done_seen = 0; aborted = 0; fetch_pc = spc; instr_pc = spc;

    while (!done_seen && !aborted && cyc < 400) begin
      if (in_wb) begin
        chk("wb_exec_low", o_exec_en, 0);
        chk("wb_fields", dut_fields(), fld(expq[ei-1]));
        in_wb = 0;
      end
      if (o_exec_en) begin
        if (ei < expq.size()) begin
          chk("exec_fields", dut_fields(), fld(expq[ei]));
          chk("exec_cycle", cyc, is_mem(expq[ei]) ? mr_cyc + 1 : fv_cyc + 2);
          in_wb = 1;
        end else begin
          chk("exec_extra", ei, expq.size());
        end
        ei++;
      end
      if (o_imem_req) begin
        chk("fetch_addr", o_imem_addr, fetch_pc);
        chk("fetch_hold", dut_fields(), fld(ir_model));
        if (iw >= cur_il) begin
          i_imem_valid = 1'b1;
          i_imem_data = imem[fetch_pc];
          ir_model = imem[fetch_pc];
          fv_cyc = cyc;
          instr_pc = fetch_pc;
          if (imem[fetch_pc][31:27] != 5'h1F) fetch_pc++;
          iw = 0;
          cur_il = pick(ilat);
        end else begin
          i_imem_valid = 1'b0;
          i_imem_data = $urandom;
          iw++;
          stalls++;
        end
      end else begin
        i_imem_valid = 1'($urandom_range(0, 1));
        i_imem_data = $urandom;
      end
      if (o_mem_req) begin
        mem_cyc++;
        if (abort_mem && mw == 3) begin
          i_abort = 1'b1;
          i_mem_ready = 1'b0;
          aborted = 1;
        end else if (!abort_mem && mw >= cur_ml) begin
          i_mem_ready = 1'b1;
          mr_cyc = cyc;
          exp_mem_cyc += cur_ml + 1;
          mw = 0;
          cur_ml = pick(mlat);
        end else begin
          i_mem_ready = 1'b0;
          mw++;
          stalls++;
        end
      end else begin
        i_mem_ready = 1'($urandom_range(0, 1));
      end
      if (o_done) begin
        chk("done_pc", o_pc, halt_pc);
        done_seen = 1;
        done_cyc = cyc;
      end
      i_start = ($urandom_range(0, 3) == 0);
      i_start_pc = 10'($urandom);
      @(negedge clk);
      cyc++;
    end
    i_start = 1'b0;
    i_imem_valid = 1'b0;
    i_mem_ready = 1'b0;

    if (aborted) begin
      i_abort = 1'b0;
      chk("abort_idle", {o_mem_req, o_busy, o_exec_en, o_imem_req}, 0);
      chk("abort_pc", o_pc, instr_pc);
      i_mem_ready = 1'b1;
      i_imem_valid = 1'b1;
      repeat (3) @(negedge clk);
      i_mem_ready = 1'b0;
      i_imem_valid = 1'b0;
      chk("abort_ignore", {o_mem_req, o_busy, o_exec_en, o_imem_req, o_pc}, {4'b0, instr_pc});
    end else begin
      chk("done_seen", done_seen, 1);
      chk("idle_after", {o_busy, o_done, o_exec_en, o_mem_req, o_imem_req}, 0);
      chk("exec_count", ei, expq.size());
      chk("mem_cycles", mem_cyc, exp_mem_cyc);
`ifdef SHADER_ISSUE_PERF_EN
      chk("perf_instr", o_perf_instr, expq.size());
      chk("perf_stall", o_perf_stall, stalls);
      chk("perf_cycles", o_perf_cycles, done_cyc);
`endif
    end
  endtask

  initial begin
    logic [9:0] p, spc;
    int         n;
    logic [4:0] op;
    rst = 1'b1; i_start = 1'b0; i_start_pc = '0; i_abort = 1'b0;
    i_imem_valid = 1'b0; i_imem_data = '0; i_mem_ready = 1'b0;
    for (int a = 0; a < 1024; a++) imem[a] = {5'h1F, 27'd0};
    ir_model = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {o_imem_req, o_imem_addr, o_exec_en, dut_fields(), o_mem_req,
                          o_busy, o_done, o_pc}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_start", {o_busy, o_imem_req, o_pc}, 0);

    // ADD then HALT, zero-latency memory
    imem[10'h005] = enc(5'h01, 4'd3, 4'd1, 4'd2);
    imem[10'h006] = enc(5'h1F, 4'd0, 4'd0, 4'd0);
    run_prog(10'h005, 0, 0, 0);

    // LOAD with 5-cycle data-memory wait
    imem[10'h020] = enc(5'h10, 4'd4, 4'd5, 4'd6);
    imem[10'h021] = enc(5'h1F, 4'd0, 4'd0, 4'd0);
    run_prog(10'h020, 0, 5, 0);

    // NOP at the top of the address space, HALT after wrap
    imem[10'h3FF] = enc(5'h00, 4'd7, 4'd7, 4'd7);
    imem[10'h000] = enc(5'h1F, 4'd0, 4'd0, 4'd0);
    run_prog(10'h3FF, 0, 0, 0);

    // dependent ADDs with 3-cycle fetch latency
    imem[10'h040] = enc(5'h01, 4'd1, 4'd2, 4'd3);
    imem[10'h041] = enc(5'h01, 4'd4, 4'd1, 4'd1);
    imem[10'h042] = enc(5'h1F, 4'd0, 4'd0, 4'd0);
    run_prog(10'h040, 3, 0, 0);

    // abort while waiting on data memory, then restart
    imem[10'h060] = enc(5'h11, 4'd2, 4'd9, 4'd8);
    imem[10'h061] = enc(5'h1F, 4'd0, 4'd0, 4'd0);
    run_prog(10'h060, 0, 0, 1);
    run_prog(10'h040, 1, 0, 0);

    // three ALU ops with 2 fetch stall cycles each
    imem[10'h080] = enc(5'h02, 4'd1, 4'd2, 4'd3);
    imem[10'h081] = enc(5'h03, 4'd5, 4'd6, 4'd7);
    imem[10'h082] = enc(5'h04, 4'd8, 4'd9, 4'd10);
    imem[10'h083] = enc(5'h1F, 4'd0, 4'd0, 4'd0);
    run_prog(10'h080, 2, 0, 0);

    // reset and abort together mid-fetch
    @(negedge clk);
    i_start = 1'b1;
    i_start_pc = 10'h123;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    i_abort = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_abort = 1'b0;
    chk("rst_over_abort", {o_pc, o_busy, o_imem_req, dut_fields()}, 0);
    ir_model = '0;

    // random programs
    repeat (10) begin
      p = 10'($urandom);
      spc = p;
      n = int'($urandom_range(2, 6));
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 7))
          0:       op = 5'h00;
          1:       op = 5'h10;
          2:       op = 5'h11;
          default: op = 5'($urandom_range(1, 14));
        endcase
        imem[p] = enc(op, 4'($urandom), 4'($urandom), 4'($urandom));
        p++;
      end
      imem[p] = enc(5'h1F, 4'($urandom), 4'($urandom), 4'($urandom));
      run_prog(spc, -1, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
